// File: rtl/data_cache_miss_ctrl_pkg.sv
// Shared definitions for the data-cache miss controller: FSM encoding,
// default geometry and address-slicing helpers.
package data_cache_miss_ctrl_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int BYTE_OFF       = 2;
    localparam int LINE_WORDS_DEF = 8;
    localparam int TAG_W_DEF      = 20;
    localparam int IDX_W_DEF      = 7;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        WB_WAIT,
        RF_REQ,
        RF_DATA,
        TAG_UPD,
        RESP
    } state_e;

    // Word-offset width inside a line (OFF).
    function automatic int off_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    localparam int OFF_DEF = off_bits(LINE_WORDS_DEF);

endpackage

// File: rtl/data_cache_miss_ctrl.sv
// Data-cache miss controller: tag lookup, optional dirty writeback,
// line refill into the data RAM, tag/valid update and CPU response.
module data_cache_miss_ctrl
    import data_cache_miss_ctrl_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int TAG_W      = TAG_W_DEF,
    parameter int IDX_W      = IDX_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    // CPU side
    input  logic                            req_valid,
    input  logic [ADDR_W-1:0]               req_addr,
    output logic                            req_ready,
    output logic                            resp_valid,
    // Tag/valid RAM
    output logic                            tagv_en,
    output logic                            tagv_wen,
    output logic [IDX_W-1:0]                tagv_index,
    output logic [TAG_W-1:0]                tagv_tag,
    output logic                            tagv_valid,
    input  logic                            lk_hit,
    input  logic                            lk_valid,
    input  logic                            lk_dirty,
    input  logic [TAG_W-1:0]                lk_tag,
    // Memory refill
    output logic                            rd_req,
    output logic [ADDR_W-1:0]               rd_addr,
    input  logic                            rd_gnt,
    input  logic                            ret_valid,
    input  logic                            ret_last,
    input  logic [DATA_W-1:0]               ret_data,
    // Writeback
    output logic                            wb_req,
    output logic [ADDR_W-1:0]               wb_addr,
    input  logic                            wb_gnt,
    input  logic                            wb_done,
    // Data RAM write
    output logic                            dram_wen,
    output logic [off_bits(LINE_WORDS)-1:0] dram_word,
    output logic [DATA_W-1:0]               dram_wdata
);

    localparam int OFF   = off_bits(LINE_WORDS);
    localparam int CNT_W = OFF;

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   tag_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TAG_W-1:0]   wb_tag_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;

    // Byte and word offsets of the request never leave this block.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[OFF+BYTE_OFF-1:0];

    // NOTE: state is registered with non-blocking assignments so every flop
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tag_q    <= '0;
            idx_q    <= '0;
            wb_tag_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tag_q <= req_addr[ADDR_W-1 -: TAG_W];
                idx_q <= req_addr[IDX_W+OFF+BYTE_OFF-1 : OFF+BYTE_OFF];
            end
            if (state_q == LOOKUP)
                wb_tag_q <= lk_tag;
            if (state_q == RF_REQ && rd_gnt)
                cnt_q <= '0;
            else if (state_q == RF_DATA && ret_valid)
                cnt_q <= (cnt_q == CNT_W'(LINE_WORDS - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: every output and state_d gets a default before the case so no
    // path through the block leaves a value held, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        tagv_en    = 1'b0;
        tagv_wen   = 1'b0;
        tagv_index = '0;
        tagv_tag   = '0;
        tagv_valid = 1'b0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        wb_req     = 1'b0;
        wb_addr    = '0;
        dram_wen   = 1'b0;
        dram_word  = '0;
        dram_wdata = '0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                // Reset holds IDLE; the lookup must not launch while it is asserted.
                if (req_valid && !rst) begin
                    accept     = 1'b1;
                    tagv_en    = 1'b1;
                    tagv_index = req_addr[IDX_W+OFF+BYTE_OFF-1 : OFF+BYTE_OFF];
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lk_hit)
                    state_d = RESP;
                else if (lk_valid && lk_dirty)
                    state_d = WB_REQ;
                else
                    state_d = RF_REQ;
            end
            WB_REQ: begin
                wb_req  = 1'b1;
                wb_addr = {wb_tag_q, idx_q, {(OFF+BYTE_OFF){1'b0}}};
                if (wb_gnt)
                    state_d = WB_WAIT;
            end
            WB_WAIT: begin
                if (wb_done)
                    state_d = RF_REQ;
            end
            RF_REQ: begin
                rd_req  = 1'b1;
                rd_addr = {tag_q, idx_q, {(OFF+BYTE_OFF){1'b0}}};
                if (rd_gnt)
                    state_d = RF_DATA;
            end
            RF_DATA: begin
                if (ret_valid) begin
                    dram_wen   = 1'b1;
                    dram_word  = cnt_q;
                    dram_wdata = ret_data;
                    if (ret_last)
                        state_d = TAG_UPD;
                end
            end
            TAG_UPD: begin
                tagv_en    = 1'b1;
                tagv_wen   = 1'b1;
                tagv_index = idx_q;
                tagv_tag   = tag_q;
                tagv_valid = 1'b1;
                state_d    = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_cache_miss_ctrl.sv
// Directed bench for data_cache_miss_ctrl: hit, clean/dirty miss, reset
// mid-refill, early last beat and counter wrap.
module tb_data_cache_miss_ctrl;

    localparam int LINE_WORDS = 8;
    localparam int TAG_W      = 20;
    localparam int IDX_W      = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic [31:0]       req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic              tagv_en;
    logic              tagv_wen;
    logic [IDX_W-1:0]  tagv_index;
    logic [TAG_W-1:0]  tagv_tag;
    logic              tagv_valid;
    logic              lk_hit;
    logic              lk_valid;
    logic              lk_dirty;
    logic [TAG_W-1:0]  lk_tag;
    logic              rd_req;
    logic [31:0]       rd_addr;
    logic              rd_gnt;
    logic              ret_valid;
    logic              ret_last;
    logic [31:0]       ret_data;
    logic              wb_req;
    logic [31:0]       wb_addr;
    logic              wb_gnt;
    logic              wb_done;
    logic              dram_wen;
    logic [2:0]        dram_word;
    logic [31:0]       dram_wdata;

    int checks = 0;
    int errors = 0;

    data_cache_miss_ctrl #(
        .LINE_WORDS(LINE_WORDS),
        .TAG_W     (TAG_W),
        .IDX_W     (IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .tagv_en   (tagv_en),
        .tagv_wen  (tagv_wen),
        .tagv_index(tagv_index),
        .tagv_tag  (tagv_tag),
        .tagv_valid(tagv_valid),
        .lk_hit    (lk_hit),
        .lk_valid  (lk_valid),
        .lk_dirty  (lk_dirty),
        .lk_tag    (lk_tag),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data),
        .wb_req    (wb_req),
        .wb_addr   (wb_addr),
        .wb_gnt    (wb_gnt),
        .wb_done   (wb_done),
        .dram_wen  (dram_wen),
        .dram_word (dram_word),
        .dram_wdata(dram_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = '0;
        lk_hit    = 1'b0;
        lk_valid  = 1'b0;
        lk_dirty  = 1'b0;
        lk_tag    = '0;
        rd_gnt    = 1'b0;
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        ret_data  = '0;
        wb_gnt    = 1'b0;
        wb_done   = 1'b0;
    endtask

    task automatic accept(input logic [31:0] addr, input logic [6:0] exp_idx);
        step();
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        check("accept_ready", 32'(req_ready), 32'd1);
        check("accept_tagv_en", 32'(tagv_en), 32'd1);
        check("accept_tagv_index", 32'(tagv_index), 32'(exp_idx));
        check("accept_tagv_wen", 32'(tagv_wen), 32'd0);
    endtask

    task automatic lookup(input logic hit, input logic valid, input logic dirty,
                          input logic [19:0] tag);
        step();
        lk_hit   = hit;
        lk_valid = valid;
        lk_dirty = dirty;
        lk_tag   = tag;
        #1;
        check("lookup_ready", 32'(req_ready), 32'd0);
        check("lookup_reqs", 32'({rd_req, wb_req, tagv_en}), 32'd0);
    endtask

    task automatic rf_req(input logic [31:0] exp_addr, input int waits);
        for (int i = 0; i <= waits; i++) begin
            step();
            rd_gnt = (i == waits);
            #1;
            check("rf_rd_req", 32'(rd_req), 32'd1);
            check("rf_rd_addr", rd_addr, exp_addr);
            check("rf_no_wb_req", 32'(wb_req), 32'd0);
        end
    endtask

    task automatic refill(input int beats, input logic [31:0] seed, input logic with_last);
        for (int i = 0; i < beats; i++) begin
            step();
            ret_valid = 1'b1;
            ret_data  = seed + 32'(i);
            ret_last  = with_last && (i == beats - 1);
            #1;
            check("beat_wen", 32'(dram_wen), 32'd1);
            check("beat_word", 32'(dram_word), 32'(i % LINE_WORDS));
            check("beat_wdata", dram_wdata, seed + 32'(i));
            check("beat_no_tagv_wen", 32'(tagv_wen), 32'd0);
        end
    endtask

    task automatic tag_upd(input logic [19:0] tag, input logic [6:0] idx);
        step();
        #1;
        check("tu_en_wen_valid", 32'({tagv_en, tagv_wen, tagv_valid}), 32'b111);
        check("tu_tag", 32'(tagv_tag), 32'(tag));
        check("tu_index", 32'(tagv_index), 32'(idx));
        check("tu_no_dram_wen", 32'(dram_wen), 32'd0);
    endtask

    task automatic resp();
        step();
        #1;
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_quiet", 32'({tagv_wen, rd_req, wb_req, req_ready}), 32'd0);
        step();
        #1;
        check("resp_one_cycle", 32'(resp_valid), 32'd0);
        check("idle_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        step();
        req_valid = 1'b1;
        req_addr  = 32'h0000_1040;
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_outputs", 32'({resp_valid, tagv_en, tagv_wen, tagv_valid, rd_req,
                                  wb_req, dram_wen}), 32'd0);
        check("rst_addrs", rd_addr | wb_addr | 32'(tagv_index) | 32'(dram_word), 32'd0);
        step();
        rst = 1'b0;

        // Hit: acceptance cycle, LOOKUP, then RESP on the third cycle.
        accept(32'h0000_1040, 7'd2);
        lookup(1'b1, 1'b1, 1'b0, 20'h00001);
        resp();

        // Clean miss with grant after 2 cycles and a full 8-beat line.
        accept(32'h8765_432C, 7'h19);
        lookup(1'b0, 1'b0, 1'b0, 20'h0);
        rf_req(32'h8765_4320, 2);
        refill(8, 32'hD000_0000, 1'b1);
        tag_upd(20'h87654, 7'h19);
        resp();

        // Dirty miss: writeback of the victim tag, refill only after wb_done.
        accept(32'h0000_1040, 7'd2);
        lookup(1'b0, 1'b1, 1'b1, 20'h12345);
        for (int i = 0; i < 4; i++) begin
            step();
            lk_tag = 20'hFFFFF;
            wb_gnt = (i == 3);
            #1;
            check("wb_req", 32'(wb_req), 32'd1);
            check("wb_addr", wb_addr, 32'h1234_5040);
            check("wb_no_rd_req", 32'(rd_req), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            wb_done = (i == 2);
            #1;
            check("wbw_quiet", 32'({wb_req, rd_req}), 32'd0);
        end
        rf_req(32'h0000_1040, 0);
        refill(1, 32'hC000_0000, 1'b1);
        tag_upd(20'h00001, 7'd2);
        resp();

        // Reset after beat 3 of a refill abandons the transaction.
        accept(32'h0000_2080, 7'd4);
        lookup(1'b0, 1'b0, 1'b0, 20'h0);
        rf_req(32'h0000_2080, 0);
        refill(3, 32'hE000_0000, 1'b0);
        step();
        rst       = 1'b1;
        ret_valid = 1'b1;
        ret_data  = 32'hDEAD_BEEF;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_outputs", 32'({dram_wen, tagv_en, tagv_wen, rd_req, wb_req,
                                      resp_valid}), 32'd0);
        check("mid_rst_word", 32'(dram_word), 32'd0);
        step();
        ret_valid = 1'b1;
        ret_last  = 1'b1;
        #1;
        check("mid_rst_hold", 32'({dram_wen, tagv_wen}), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            rst       = 1'b0;
            ret_valid = 1'b1;
            ret_last  = 1'b1;
            #1;
            check("post_rst_no_write", 32'({dram_wen, tagv_en, tagv_wen}), 32'd0);
            check("post_rst_ready", 32'(req_ready), 32'd1);
        end

        // Early last on beat 4 ends the refill; counter left at 4.
        accept(32'h0000_2080, 7'd4);
        lookup(1'b0, 1'b0, 1'b0, 20'h0);
        rf_req(32'h0000_2080, 0);
        refill(4, 32'hA000_0000, 1'b1);
        tag_upd(20'h00002, 7'd4);
        resp();

        // Valid-but-clean victim: refill restarts at word 0 and wraps past 8 beats.
        accept(32'hFFFF_FFFC, 7'h7F);
        lookup(1'b0, 1'b1, 1'b0, 20'h55555);
        rf_req(32'hFFFF_FFE0, 1);
        refill(10, 32'hB000_0000, 1'b1);
        tag_upd(20'hFFFFF, 7'h7F);
        resp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
